// File: rtl/tetris_input_pkg.sv
//============================================================================
// Module   : tetris_input_pkg
// Purpose  : Shared channel indices, repeat-FSM states and width helper.
// Revision : 1.0
//============================================================================
`default_nettype none

package tetris_input_pkg;

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_DOWN  = 2;
  localparam int CH_FRZ   = 3;

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rp_state_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_input_channel.sv
//============================================================================
// Module   : tetris_input_channel
// Purpose  : One input channel: synchroniser, debouncer, edge pulses and
//            hold-to-repeat. Optional macro INPUT_ACCEL_EN shortens repeats.
// Revision : 1.0
//============================================================================
`default_nettype none

module tetris_input_channel
  import tetris_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_mask,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic move_o
);

  localparam int DBW    = cnt_width(DEBOUNCE_CYCLES);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW    = cnt_width(RP_MAX);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] DLY_LAST = RPW'(REPEAT_DELAY - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("tetris_input_channel: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_count
    $error("tetris_input_channel: all cycle counts must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DBW-1:0]         r_db_cnt;
  logic                   r_lvl;
  rp_state_e              r_state, w_state_nx;
  logic [RPW-1:0]         r_rp_cnt, w_cnt_nx, w_rpt_last;
  logic                   w_sync, w_rise, w_fall, w_abort;
  logic                   w_dly_hit, w_rpt_hit, w_tick;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync   <= '0;
      r_db_cnt <= '0;
      r_lvl    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      if (w_sync == r_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_lvl    <= ~r_lvl;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // level_o is the registered copy of r_lvl, so it doubles as edge history.
  assign w_rise  = r_lvl & ~level_o;
  assign w_fall  = ~r_lvl & level_o;
  assign w_abort = w_fall | ~repeat_mask;

`ifdef INPUT_ACCEL_EN
  localparam int ACC_STEP = (REPEAT_RATE / 4 < 1) ? 1 : REPEAT_RATE / 4;
  logic [RPW-1:0] r_ivl, w_ivl_nx;
  assign w_rpt_last = r_ivl - RPW'(1);
`else
  assign w_rpt_last = RPW'(REPEAT_RATE - 1);
`endif

  assign w_dly_hit = (r_state == RP_DELAY)  && (r_rp_cnt == DLY_LAST);
  assign w_rpt_hit = (r_state == RP_REPEAT) && (r_rp_cnt == w_rpt_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RP_IDLE;
      r_rp_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_rp_cnt <= w_cnt_nx;
    end
  end

`ifdef INPUT_ACCEL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ivl <= RPW'(REPEAT_RATE);
    else        r_ivl <= w_ivl_nx;
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_rp_cnt + 1'b1;
`ifdef INPUT_ACCEL_EN
    w_ivl_nx   = r_ivl;
`endif
    case (r_state)
      RP_IDLE: begin
        w_cnt_nx = '0;
        if (w_rise && repeat_mask) w_state_nx = RP_DELAY;
      end
      RP_DELAY: begin
        if (w_dly_hit) begin
          w_state_nx = RP_REPEAT;
          w_cnt_nx   = '0;
        end
      end
      RP_REPEAT: begin
        if (w_rpt_hit) begin
          w_cnt_nx = '0;
`ifdef INPUT_ACCEL_EN
          w_ivl_nx = (int'(r_ivl) > 2 * ACC_STEP) ? r_ivl - RPW'(ACC_STEP) : RPW'(ACC_STEP);
`endif
        end
      end
      default: begin
        w_state_nx = RP_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    if (w_abort) begin
      w_state_nx = RP_IDLE;
      w_cnt_nx   = '0;
    end
`ifdef INPUT_ACCEL_EN
    if (w_state_nx == RP_IDLE) w_ivl_nx = RPW'(REPEAT_RATE);
`endif
  end

  always_comb begin
    w_tick = ~w_abort & (w_dly_hit | w_rpt_hit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      move_o    <= 1'b0;
    end else begin
      level_o   <= r_lvl;
      press_o   <= w_rise;
      release_o <= w_fall;
      move_o    <= w_rise | w_tick;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tetris_input_conditioner.sv
//============================================================================
// Module   : tetris_input_conditioner
// Purpose  : N_CH-wide button conditioner; replicates tetris_input_channel.
//            Optional macro INPUT_ACCEL_EN enables repeat acceleration.
// Revision : 1.0
//============================================================================
`default_nettype none

module tetris_input_conditioner
  import tetris_input_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] repeat_mask,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] move_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tetris_input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .repeat_mask(repeat_mask[i]),
      .level_o    (level_o[i]),
      .press_o    (press_o[i]),
      .release_o  (release_o[i]),
      .move_o     (move_o[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_tetris_input_conditioner.sv
//============================================================================
// Module   : tb_tetris_input_conditioner
// Purpose  : Directed + random bench with a timing-level reference model.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_tetris_input_conditioner;

  localparam int N    = 4;
  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;
  localparam int STEP = (RATE / 4 < 1) ? 1 : RATE / 4;
`ifdef INPUT_ACCEL_EN
  localparam int GAP2 = 2;
`else
  localparam int GAP2 = 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] repeat_mask = 4'b0111;
  logic [N-1:0] level_o, press_o, release_o, move_o;

  always #5 clk = ~clk;

  tetris_input_conditioner #(
    .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .repeat_mask(repeat_mask),
    .level_o(level_o), .press_o(press_o), .release_o(release_o), .move_o(move_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: raw delayed by SS edges, run-length debounce, and
  // tick times scheduled as absolute cycle numbers from the press.
  logic [N-1:0] m_hist [SS];
  logic [N-1:0] m_int, m_level, m_press, m_release, m_move;
  int m_run [N];
  int m_next [N];
  int m_ivl [N];
  bit m_act [N];
  bit m_inrep [N];

  int mv_q[$];
  int pr_cyc [N];
  int pr_cnt [N];
  int mv_cnt [N];
  int hi_cnt [N];
  int hold [N];

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    m_int = '0; m_level = '0; m_press = '0; m_release = '0; m_move = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_act[c] = 0; m_inrep[c] = 0; m_ivl[c] = RATE; m_next[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] s, lv;
    s = m_hist[SS-1];
    for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = btn_raw;
    lv = m_int;
    for (int c = 0; c < N; c++) begin
      if (s[c] != m_int[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_int[c] = s[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_press   = lv & ~m_level;
    m_release = ~lv & m_level;
    m_level   = lv;
    m_move    = m_press;
    for (int c = 0; c < N; c++) begin
      if (m_release[c] || !repeat_mask[c]) begin
        m_act[c] = 0;
      end else if (m_press[c]) begin
        m_act[c] = 1; m_next[c] = cyc + DLY; m_ivl[c] = RATE; m_inrep[c] = 0;
      end else if (m_act[c] && cyc == m_next[c]) begin
        m_move[c] = 1'b1;
`ifdef INPUT_ACCEL_EN
        if (m_inrep[c]) m_ivl[c] = (m_ivl[c] - STEP > STEP) ? m_ivl[c] - STEP : STEP;
`endif
        m_inrep[c] = 1;
        m_next[c]  = cyc + m_ivl[c];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset) model_edge();
    @(negedge clk);
    chk("level", level_o, m_level);
    chk("press", press_o, m_press);
    chk("release", release_o, m_release);
    chk("move", move_o, m_move);
    for (int c = 0; c < N; c++) begin
      if (press_o[c]) begin pr_cyc[c] = cyc; pr_cnt[c]++; end
      if (move_o[c]) mv_cnt[c]++;
      if (level_o[c]) hi_cnt[c]++;
    end
    if (move_o[0]) mv_q.push_back(cyc);
  endtask

  task automatic wait_press(input int ch, input int lim, output int c, output logic [N-1:0] v);
    c = -1; v = '0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (press_o[ch]) begin c = cyc; v = press_o; break; end
    end
  endtask

  task automatic wait_rel(input int ch, input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      step();
      if (release_o[ch]) begin c = cyc; break; end
    end
  endtask

  initial begin
    int e, c, c2, r, p, m, h;
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      pr_cyc[i] = -1; pr_cnt[i] = 0; mv_cnt[i] = 0; hi_cnt[i] = 0; hold[i] = 0;
    end
    model_reset();
    repeat (3) step();
    reset = 1'b1;
    repeat (8) step();

    // 1: LEFT press latency and repeat schedule
    mv_q.delete();
    btn_raw[0] = 1'b1; e = cyc + 1;
    repeat (30) step();
    chki("t1_press_cyc", pr_cyc[0], e + 6);
    while (mv_q.size() < 4) mv_q.push_back(-1);
    chki("t1_mv0", mv_q[0], e + 6);
    chki("t1_mv1", mv_q[1], e + 16);
    chki("t1_mv2", mv_q[2], e + 19);
    chki("t1_mv3", mv_q[3], e + 19 + GAP2);
    btn_raw[0] = 1'b0;
    repeat (12) step();

    // 2: short glitches on RIGHT never reach level
    h = hi_cnt[1]; p = pr_cnt[1]; m = mv_cnt[1];
    repeat (5) begin
      btn_raw[1] = 1'b1; repeat (3) step();
      btn_raw[1] = 1'b0; repeat (3) step();
    end
    repeat (8) step();
    chki("t2_level_hi", hi_cnt[1] - h, 0);
    chki("t2_press", pr_cnt[1] - p, 0);
    chki("t2_move", mv_cnt[1] - m, 0);

    // 3: FRZ (mask=0) held: single press, release after full latency
    p = pr_cnt[3]; m = mv_cnt[3];
    btn_raw[3] = 1'b1;
    repeat (40) step();
    btn_raw[3] = 1'b0; e = cyc + 1;
    wait_rel(3, 20, c);
    chki("t3_release_cyc", c, e + 6);
    chki("t3_press_cnt", pr_cnt[3] - p, 1);
    chki("t3_move_cnt", mv_cnt[3] - m, 1);
    repeat (6) step();

    // 4: DOWN released on the cycle its second tick would fire
    btn_raw[2] = 1'b1;
    wait_press(2, 20, c, v);
    m = mv_cnt[2];
    repeat (6) step();
    btn_raw[2] = 1'b0;
    wait_rel(2, 20, c2);
    chki("t4_release_cyc", c2, c + 13);
    chk("t4_no_move", move_o & 4'b0100, 4'b0000);
    chki("t4_ticks", mv_cnt[2] - m, 1);
    repeat (15) step();
    chki("t4_idle", mv_cnt[2] - m, 1);

    // 5: reset mid-REPEAT with LEFT held
    btn_raw[0] = 1'b1;
    wait_press(0, 20, c, v);
    repeat (20) step();
    reset = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_level", level_o, '0);
    chk("t5_rst_move", move_o, '0);
    repeat (5) step();
    reset = 1'b1; r = cyc;
    wait_press(0, 20, c, v);
    chki("t5_fresh_press", c, r + 7);
    btn_raw[0] = 1'b0;
    repeat (12) step();

    // 6: simultaneous LEFT+RIGHT press and repeat gaps
    mv_q.delete();
    btn_raw[1:0] = 2'b11; e = cyc + 1;
    wait_press(0, 20, c, v);
    chk("t6_press_vec", v, 4'b0011);
    chki("t6_press_cyc", c, e + 6);
    repeat (20) step();
    while (mv_q.size() < 4) mv_q.push_back(-100);
    chki("t6_gap_delay", mv_q[1] - mv_q[0], DLY);
    chki("t6_gap1", mv_q[2] - mv_q[1], RATE);
    chki("t6_gap2", mv_q[3] - mv_q[2], GAP2);
    btn_raw = '0;
    repeat (12) step();

    // Random holds/glitches and mask changes against the model
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          btn_raw[ch] = ~btn_raw[ch];
          hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 40));
        end else begin
          hold[ch]--;
        end
      end
      if (i % 150 == 149) repeat_mask = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
